// File: rtl/wb_pkg.sv
// Shared constants and types for the DM/WB writeback stage.
package wb_pkg;

    parameter int unsigned WB_WIDTH  = 16;
    parameter int unsigned WB_ADDR_W = 4;

    parameter int unsigned SRC_DM  = 0;
    parameter int unsigned SRC_ALU = 1;
    parameter int unsigned SRC_PC  = 2;

    typedef enum logic [0:0] {
        WB_IDLE,
        WB_WAIT
    } wb_state_e;

endpackage

// File: rtl/onehot_prio_mux.sv
// Lowest-index-wins source mux with a flag for selects that are not exactly one-hot.
module onehot_prio_mux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NSRC  = 3,
    localparam int unsigned IdxW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src,
    output logic [WIDTH-1:0]      data,
    output logic [IdxW-1:0]       idx,
    output logic                  not_onehot
);

    logic found;

    always_comb begin
        data  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (sel[i] && !found) begin
                data  = src[i*WIDTH +: WIDTH];
                idx   = IdxW'(i);
                found = 1'b1;
            end
        end
    end

    // Zero or more than one bit set.
    assign not_onehot = (sel == '0) || ((sel & (sel - NSRC'(1))) != '0);

endmodule

// File: rtl/wb_src_mux_pipe.sv
// DM/WB writeback register: source mux, DM wait state, stall/flush and select-error pulse.
module wb_src_mux_pipe
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH  = WB_WIDTH,
    parameter int unsigned NSRC   = 3,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DM_SRC = SRC_DM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC-1:0]       src_sel_EX_DM,
    input  logic [NSRC*WIDTH-1:0] src_data_EX_DM,
    input  logic [ADDR_W-1:0]     dst_addr_EX_DM,
    input  logic                  we_EX_DM,
    input  logic                  dm_rdy,
    input  logic                  stall_DM_WB,
    input  logic                  flush_DM_WB,
    output logic [WIDTH-1:0]      rf_w_data_DM_WB,
    output logic [ADDR_W-1:0]     rf_dst_addr_DM_WB,
    output logic                  rf_we_DM_WB,
    output logic                  stall_req,
    output logic                  sel_err
);

    localparam int unsigned IdxW = (NSRC > 1) ? $clog2(NSRC) : 1;

    wb_state_e           state_q, state_d;
    logic [WIDTH-1:0]    data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                sel_err_q;

    logic [WIDTH-1:0]    mux_data;
    logic [IdxW-1:0]     mux_idx;
    logic                mux_bad;
    logic                dm_wait;

    onehot_prio_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_mux (
        .sel        (src_sel_EX_DM),
        .src        (src_data_EX_DM),
        .data       (mux_data),
        .idx        (mux_idx),
        .not_onehot (mux_bad)
    );

    // An all-zero select has no winner, so it never waits on the DM.
    assign dm_wait = we_EX_DM & (|src_sel_EX_DM) & (mux_idx == IdxW'(DM_SRC)) & ~dm_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_DM_WB) begin
            state_d = WB_IDLE;
        end else if (!stall_DM_WB) begin
            state_d = stall_req ? WB_WAIT : WB_IDLE;
        end
    end

    // Request is held low during reset so a pending load cannot freeze upstream.
    always_comb begin
        stall_req = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                WB_IDLE: stall_req = dm_wait;
                WB_WAIT: stall_req = ~dm_rdy;
                default: stall_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            sel_err_q <= 1'b0;
        end else if (flush_DM_WB) begin
            we_q      <= 1'b0;
            sel_err_q <= 1'b0;
        end else if (stall_DM_WB) begin
            sel_err_q <= 1'b0;
        end else if (stall_req) begin
            we_q      <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= mux_data;
            addr_q    <= dst_addr_EX_DM;
            we_q      <= we_EX_DM;
            sel_err_q <= we_EX_DM & mux_bad;
        end
    end

    assign rf_w_data_DM_WB   = data_q;
    assign rf_dst_addr_DM_WB = addr_q;
    assign rf_we_DM_WB       = we_q;
    assign sel_err           = sel_err_q;

endmodule

// File: tb/tb_wb_src_mux_pipe.sv
// Directed self-checking bench for wb_src_mux_pipe.
module tb_wb_src_mux_pipe;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  src_sel;
    logic [47:0] src_data;
    logic [3:0]  dst_addr;
    logic        we;
    logic        dm_rdy;
    logic        stall;
    logic        flush;
    logic [15:0] rf_w_data;
    logic [3:0]  rf_dst_addr;
    logic        rf_we;
    logic        stall_req;
    logic        sel_err;

    logic [15:0] dm_v, alu_v, pc_v;
    int          errors = 0;
    int          checks = 0;

    assign src_data = {pc_v, alu_v, dm_v};

    wb_src_mux_pipe dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_sel_EX_DM     (src_sel),
        .src_data_EX_DM    (src_data),
        .dst_addr_EX_DM    (dst_addr),
        .we_EX_DM          (we),
        .dm_rdy            (dm_rdy),
        .stall_DM_WB       (stall),
        .flush_DM_WB       (flush),
        .rf_w_data_DM_WB   (rf_w_data),
        .rf_dst_addr_DM_WB (rf_dst_addr),
        .rf_we_DM_WB       (rf_we),
        .stall_req         (stall_req),
        .sel_err           (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; src_sel = 3'b000; dm_v = '0; alu_v = '0; pc_v = '0;
        dst_addr = '0; we = 1'b0; dm_rdy = 1'b0; stall = 1'b0; flush = 1'b0;
        #3;
        chk("rst_data", rf_w_data, 0);
        chk("rst_addr", rf_dst_addr, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_stall_req", stall_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic ALU select
        src_sel = 3'b010; alu_v = 16'h1234; dst_addr = 4'd7; we = 1'b1;
        #1 chk("basic_stall_req", stall_req, 0);
        tick();
        chk("basic_data", rf_w_data, 16'h1234);
        chk("basic_addr", rf_dst_addr, 7);
        chk("basic_we", rf_we, 1);
        chk("basic_sel_err", sel_err, 0);

        // DM wait: dm_rdy low for three cycles
        src_sel = 3'b001; dm_v = 16'hBEEF; dst_addr = 4'd3; dm_rdy = 1'b0;
        #1 chk("dm_stall_req_c1", stall_req, 1);
        tick();
        chk("dm_stall_req_c2", stall_req, 1);
        chk("dm_we_bubble_c2", rf_we, 0);
        chk("dm_data_hold", rf_w_data, 16'h1234);
        tick();
        chk("dm_stall_req_c3", stall_req, 1);
        chk("dm_we_bubble_c3", rf_we, 0);
        tick();
        dm_rdy = 1'b1;
        #1 chk("dm_stall_req_rdy", stall_req, 0);
        chk("dm_we_bubble_c4", rf_we, 0);
        tick();
        chk("dm_data", rf_w_data, 16'hBEEF);
        chk("dm_addr", rf_dst_addr, 3);
        chk("dm_we", rf_we, 1);
        chk("dm_state_idle", 32'(dut.state_q), 32'(WB_IDLE));
        dm_rdy = 1'b0;

        // Stall hold
        src_sel = 3'b010; alu_v = 16'hAAAA; dst_addr = 4'd5;
        tick();
        chk("stall_pre_data", rf_w_data, 16'hAAAA);
        alu_v = 16'h5555; dst_addr = 4'd6; stall = 1'b1;
        tick();
        chk("stall_data_1", rf_w_data, 16'hAAAA);
        chk("stall_addr_1", rf_dst_addr, 5);
        chk("stall_we_1", rf_we, 1);
        tick();
        chk("stall_data_2", rf_w_data, 16'hAAAA);
        chk("stall_we_2", rf_we, 1);
        stall = 1'b0;
        tick();
        chk("stall_release_data", rf_w_data, 16'h5555);
        chk("stall_release_addr", rf_dst_addr, 6);

        // Flush while waiting on the DM
        src_sel = 3'b001; dm_v = 16'h1111; dst_addr = 4'd9; we = 1'b1; dm_rdy = 1'b0;
        tick();
        chk("flush_in_wait", 32'(dut.state_q), 32'(WB_WAIT));
        chk("flush_wait_we", rf_we, 0);
        flush = 1'b1;
        #1 chk("flush_stall_req_pre", stall_req, 1);
        tick();
        flush = 1'b0; src_sel = 3'b000; we = 1'b0;
        #1 chk("flush_stall_req_drop", stall_req, 0);
        chk("flush_we", rf_we, 0);
        chk("flush_data_kept", rf_w_data, 16'h5555);
        chk("flush_state_idle", 32'(dut.state_q), 32'(WB_IDLE));
        tick();
        chk("flush_after_we", rf_we, 0);

        // Illegal selects
        src_sel = 3'b110; pc_v = 16'h0040; alu_v = 16'h0001; dst_addr = 4'd2; we = 1'b1;
        tick();
        chk("multi_data", rf_w_data, 16'h0001);
        chk("multi_sel_err", sel_err, 1);
        chk("multi_we", rf_we, 1);
        src_sel = 3'b010;
        tick();
        chk("multi_sel_err_clear", sel_err, 0);
        src_sel = 3'b000; dst_addr = 4'd4;
        #1 chk("none_stall_req", stall_req, 0);
        tick();
        chk("none_data", rf_w_data, 0);
        chk("none_sel_err", sel_err, 1);
        src_sel = 3'b010; we = 1'b0;
        tick();
        chk("none_sel_err_clear", sel_err, 0);
        chk("we0_rf_we", rf_we, 0);

        // Async reset in the middle of a wait
        src_sel = 3'b001; dm_v = 16'hCAFE; dst_addr = 4'd8; we = 1'b1; dm_rdy = 1'b0;
        tick();
        chk("arst_in_wait", stall_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", rf_w_data, 0);
        chk("arst_we", rf_we, 0);
        chk("arst_stall_req", stall_req, 0);
        chk("arst_state", 32'(dut.state_q), 32'(WB_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        src_sel = 3'b010; alu_v = 16'h7777; dst_addr = 4'd1; dm_rdy = 1'b1;
        tick();
        chk("arst_after_data", rf_w_data, 16'h7777);
        chk("arst_after_addr", rf_dst_addr, 1);
        chk("arst_after_we", rf_we, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
